// File: rtl/mult_div_control.sv
// Sequencer for the iterative multiply/divide datapath unit.
// Latches the operation and operands on an accepted start, holds the unit in
// initialisation, lets it run for 32 steps, then copies its result into the
// architectural HI/LO registers. A divide-by-zero flag from the unit aborts the
// run and raises a one-cycle exception pulse instead of a completion pulse.
module mult_div_control (
    input  logic        clock,
    input  logic        Reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] RegA_out,
    input  logic [31:0] RegB_out,
    input  logic [31:0] md_Hi,
    input  logic [31:0] md_Lo,
    input  logic        md_div_zero,
    output logic        md_Reset,
    output logic        MDControl,
    output logic [31:0] md_RegA,
    output logic [31:0] md_RegB,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // Number of RUN steps the datapath needs; cnt saturates here and never wraps.
    localparam logic [5:0] CNT_LAST = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [31:0] rega_q, rega_d;
    logic [31:0] regb_q, regb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    // Divide-by-zero abort: only meaningful for a divide while the unit runs.
    logic        abort_div_zero;
    assign abort_div_zero = op_q & md_div_zero;

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so a start while busy is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (abort_div_zero) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs: the unit is held in init whenever it is not actively running.
    always_comb begin
        busy     = 1'b0;
        md_Reset = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                md_Reset = 1'b1;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                md_Reset = 1'b1;
            end
            S_RUN, S_CAPTURE: begin
                busy     = 1'b1;
                md_Reset = 1'b0;
            end
            default: begin
                busy     = 1'b0;
                md_Reset = 1'b1;
            end
        endcase
    end

    // Datapath next values: operand latch, step counter, HI/LO capture and event pulses.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        rega_d = rega_q;
        regb_d = regb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        dz_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 6'd0;
                if (start) begin
                    op_d   = op;
                    rega_d = RegA_out;
                    regb_d = RegB_out;
                end
            end
            S_CLEAR: begin
                cnt_d = 6'd0;
            end
            S_RUN: begin
                if (abort_div_zero) begin
                    dz_d  = 1'b1;
                    cnt_d = 6'd0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CAPTURE: begin
                // The only point at which the unit's result is sampled.
                hi_d   = md_Hi;
                lo_d   = md_Lo;
                done_d = 1'b1;
                cnt_d  = 6'd0;
            end
            default: begin
                cnt_d = 6'd0;
            end
        endcase
    end

    // Datapath registers; everything is cleared asynchronously so an in-flight operation leaves no trace.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= 6'd0;
            op_q   <= 1'b0;
            rega_q <= 32'd0;
            regb_q <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            rega_q <= rega_d;
            regb_q <= regb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign MDControl    = op_q;
    assign md_RegA      = rega_q;
    assign md_RegB      = regb_q;
    assign done         = done_q;
    assign div_zero_exc = dz_q;
    assign HI           = hi_q;
    assign LO           = lo_q;

endmodule

// File: tb/tb_mult_div_control.sv
// Directed bench for mult_div_control with a stub datapath unit and an event scoreboard.
module tb_mult_div_control;

    logic        clock;
    logic        Reset;
    logic        start;
    logic        op;
    logic [31:0] RegA_out;
    logic [31:0] RegB_out;
    logic [31:0] md_Hi;
    logic [31:0] md_Lo;
    logic        md_div_zero;
    logic        md_Reset;
    logic        MDControl;
    logic [31:0] md_RegA;
    logic [31:0] md_RegB;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_control dut (
        .clock       (clock),
        .Reset       (Reset),
        .start       (start),
        .op          (op),
        .RegA_out    (RegA_out),
        .RegB_out    (RegB_out),
        .md_Hi       (md_Hi),
        .md_Lo       (md_Lo),
        .md_div_zero (md_div_zero),
        .md_Reset    (md_Reset),
        .MDControl   (MDControl),
        .md_RegA     (md_RegA),
        .md_RegB     (md_RegB),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc),
        .HI          (HI),
        .LO          (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Stub datapath: counts steps while released from init; the result is only
    // valid once it has run for 32 steps, garbage otherwise.
    int          stub_cnt = 0;
    logic [31:0] stub_hi  = 32'd0;
    logic [31:0] stub_lo  = 32'd0;
    logic        dz_mode  = 1'b0;

    always @(posedge clock) stub_cnt <= md_Reset ? 0 : stub_cnt + 1;

    assign md_Hi       = (stub_cnt >= 32) ? stub_hi : 32'hDEAD_BEEF;
    assign md_Lo       = (stub_cnt >= 32) ? stub_lo : 32'hBAD0_BAD0;
    assign md_div_zero = dz_mode && !md_Reset && (stub_cnt >= 1);

    typedef struct {
        logic        is_exc;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done / div_zero_exc pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        exp_t e;
        if (Reset && (done || div_zero_exc)) begin
            if (sb.size() == 0) begin
                chk1("unexpected_done", done, 1'b0);
                chk1("unexpected_exc", div_zero_exc, 1'b0);
            end else begin
                e = sb.pop_front();
                chk1("event_done", done, !e.is_exc);
                chk1("event_exc", div_zero_exc, e.is_exc);
                chk32("event_cycle", cyc, e.due);
                chk32("event_HI", HI, e.hi);
                chk32("event_LO", LO, e.lo);
                $display("event cyc=%0d done=%b exc=%b HI=%h LO=%h", cyc, done, div_zero_exc, HI, LO);
            end
        end
    end

    // Drive a start for one cycle; returns the cycle count right after the sampling edge.
    task automatic do_start(input logic o, input logic [31:0] a, input logic [31:0] b, output int c0);
        @(negedge clock);
        start    = 1'b1;
        op       = o;
        RegA_out = a;
        RegB_out = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        c0    = cyc;
        $display("start op=%b A=%h B=%h accepted at cyc=%0d", o, a, b, c0);
    endtask

    task automatic push_done(input int due, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.is_exc = 1'b0;
        e.hi     = h;
        e.lo     = l;
        e.due    = due;
        sb.push_back(e);
    endtask

    initial begin
        int   c0;
        int   c1;
        bit   seen;
        exp_t ez;

        Reset    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        RegA_out = 32'd0;
        RegB_out = 32'd0;

        // Reset state
        #2;
        chk32("rst_HI", HI, 32'd0);
        chk32("rst_LO", LO, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_md_Reset", md_Reset, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_exc", div_zero_exc, 1'b0);
        chk1("rst_MDControl", MDControl, 1'b0);
        chk32("rst_md_RegA", md_RegA, 32'd0);
        chk32("rst_md_RegB", md_RegB, 32'd0);
        repeat (2) @(negedge clock);
        Reset = 1'b1;

        // Multiply: busy for exactly 35 cycles, result after 35 edges
        stub_hi = 32'hFFFF_FFFF;
        stub_lo = 32'hFFFF_FFEB;
        do_start(1'b0, 32'd7, 32'hFFFF_FFFD, c0);
        push_done(c0 + 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        for (int i = 0; i < 35; i++) begin
            chk1("mul_busy", busy, 1'b1);
            if (i == 0) chk1("mul_md_Reset_clear", md_Reset, 1'b1);
            if (i == 1) chk1("mul_md_Reset_run", md_Reset, 1'b0);
            @(posedge clock);
            #1;
        end
        chk1("mul_busy_end", busy, 1'b0);
        chk1("mul_done_pulse", done, 1'b1);
        @(posedge clock);
        #1;
        chk1("mul_done_clears", done, 1'b0);

        // Divide with operand toggling and a start while busy at cnt=5
        stub_hi = 32'h0000_0002;
        stub_lo = 32'h0000_000E;
        do_start(1'b1, 32'd100, 32'd7, c0);
        push_done(c0 + 35, 32'h0000_0002, 32'h0000_000E);
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            RegA_out = ~RegA_out;
            RegB_out = $urandom;
            op       = ~op;
            start    = (cyc == c0 + 6);
            if (i > 0) begin
                chk32("div_md_RegA_hold", md_RegA, 32'd100);
                chk32("div_md_RegB_hold", md_RegB, 32'd7);
                chk1("div_MDControl", MDControl, 1'b1);
            end
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        chk1("div_done_seen", seen, 1'b1);

        // Start in the done cycle is accepted
        stub_hi = 32'h1234_5678;
        stub_lo = 32'h9ABC_DEF0;
        start    = 1'b1;
        op       = 1'b0;
        RegA_out = 32'd3;
        RegB_out = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        c1    = cyc;
        $display("start in done cycle accepted at cyc=%0d", c1);
        chk1("chain_busy", busy, 1'b1);
        push_done(c1 + 35, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (37) @(posedge clock);
        #1;
        chk32("chain_HI", HI, 32'h1234_5678);

        // Divide by zero: exception pulse, HI/LO untouched, no done
        dz_mode = 1'b1;
        stub_hi = 32'h5555_5555;
        stub_lo = 32'hAAAA_AAAA;
        do_start(1'b1, 32'd55, 32'd0, c0);
        ez.is_exc = 1'b1;
        ez.hi     = 32'h1234_5678;
        ez.lo     = 32'h9ABC_DEF0;
        ez.due    = c0 + 3;
        sb.push_back(ez);
        repeat (5) @(posedge clock);
        #1;
        dz_mode = 1'b0;
        chk1("dz_busy", busy, 1'b0);
        chk32("dz_HI_kept", HI, 32'h1234_5678);
        chk32("dz_LO_kept", LO, 32'h9ABC_DEF0);
        repeat (40) @(posedge clock);
        #1;
        chk32("dz_HI_later", HI, 32'h1234_5678);

        // Asynchronous reset at cnt=10
        stub_hi = 32'h0BAD_F00D;
        stub_lo = 32'h0BAD_F00D;
        do_start(1'b0, 32'd9, 32'd9, c0);
        repeat (11) @(posedge clock);
        #2;
        Reset = 1'b0;
        #1;
        chk32("arst_HI", HI, 32'd0);
        chk32("arst_LO", LO, 32'd0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_md_Reset", md_Reset, 1'b1);
        chk32("arst_md_RegA", md_RegA, 32'd0);
        repeat (3) @(negedge clock);
        Reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk32("arst_HI_after", HI, 32'd0);

        // Operation after reset release
        stub_hi = 32'h0000_0001;
        stub_lo = 32'h0000_0002;
        do_start(1'b1, 32'd11, 32'd4, c0);
        push_done(c0 + 35, 32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        chk32("sb_empty", sb.size(), 32'd0);
        chk32("final_LO", LO, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
